// File: rtl/qec_ctrl_pkg.sv
// qec_ctrl_pkg: shared loader state encoding, index-width helper and decoder coordinate width.
package qec_ctrl_pkg;
  localparam int CORDINATE_WIDTH = 8;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PUBLISH,
    S_SETTLE,
    S_OFFER,
    S_STOP,
    S_DONE
  } loader_state_e;
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/syndrome_loader_ctrl_phase_timer.sv
// phase_timer: loadable down-counter; o_expire pulses once the loaded count has fully elapsed.
module phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_expire
);
  logic [W-1:0] r_cnt;
  logic         r_run;
  always_ff @(posedge clk) begin
    if (!reset || i_clear) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_load) begin
      r_cnt <= i_value;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_run <= r_cnt != '0;
      r_cnt <= r_cnt == '0 ? r_cnt : r_cnt - 1'b1;
    end
  end
  assign o_expire = r_run && r_cnt == '0;
endmodule

// File: rtl/syndrome_loader_ctrl.sv
// syndrome_loader_ctrl: serial syndrome frame loader and decoder offer sequencer.
// Define LOADER_DEFECT_COUNT_EN to add the defect_count popcount output.
module syndrome_loader_ctrl
  import qec_ctrl_pkg::*;
#(
  parameter int GRID_H        = 2,
  parameter int GRID_W        = 3,
  parameter int SETTLE_CYCLES = 100,
  parameter int OFFER_CYCLES  = 2500,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     syn_bit_in,
  input  logic                     syn_valid_in,
  input  logic                     syn_last_in,
  output logic                     syn_ready_out,
  input  logic                     abort_in,
  output logic [GRID_H*GRID_W-1:0] measurement_value_out,
  output logic                     measurement_valid_out,
  output logic                     start_offer,
  output logic                     stop_offer,
  output logic                     busy,
  output logic                     done,
  output logic                     frame_err
`ifdef LOADER_DEFECT_COUNT_EN
  ,
  output logic [$clog2(GRID_H*GRID_W+1)-1:0] defect_count
`endif
);
  localparam int N = GRID_H * GRID_W;
  localparam int IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if (SETTLE_CYCLES >= 2 ** CNT_WIDTH || OFFER_CYCLES >= 2 ** CNT_WIDTH) begin : g_cnt_chk
    $error("CNT_WIDTH cannot hold SETTLE_CYCLES/OFFER_CYCLES");
  end
  if (GRID_H > 2 ** CORDINATE_WIDTH || GRID_W > 2 ** CORDINATE_WIDTH) begin : g_crd_chk
    $error("grid exceeds decoder coordinate range");
  end

  loader_state_e        r_state, w_next;
  logic [IDX_W-1:0]     r_idx;
  logic [N-1:0]         r_shift, r_value;
  logic                 r_valid, r_start, r_aborted, r_frame_err;
  logic                 w_accept, w_last_idx, w_bad, w_good, w_expire, w_fire;
  logic                 w_timer_load, w_timer_clear;
  logic [CNT_WIDTH-1:0] w_timer_val;

  assign syn_ready_out = r_state == S_IDLE || r_state == S_LOAD;
  assign w_accept      = syn_valid_in && syn_ready_out;
  assign w_last_idx    = r_idx == LAST_IDX;
  assign w_bad         = w_accept && (w_last_idx != syn_last_in);
  assign w_good        = w_accept && w_last_idx && syn_last_in;
  // abort beats a coincident expiry, so start_offer is suppressed here
  assign w_fire        = r_state == S_SETTLE && w_expire && !abort_in;
  assign w_timer_load  = r_state == S_PUBLISH || w_fire;
  assign w_timer_clear = abort_in && (r_state == S_SETTLE || r_state == S_OFFER);
  assign w_timer_val   = r_state == S_PUBLISH ? CNT_WIDTH'(SETTLE_CYCLES) : CNT_WIDTH'(OFFER_CYCLES);

  phase_timer #(.W(CNT_WIDTH)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_timer_clear),
    .i_load   (w_timer_load),
    .i_value  (w_timer_val),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_LOAD: w_next = w_bad ? S_IDLE : w_good ? S_PUBLISH : w_accept ? S_LOAD : r_state;
      S_PUBLISH:      w_next = S_SETTLE;
      S_SETTLE:       w_next = abort_in ? S_IDLE : w_expire ? S_OFFER : S_SETTLE;
      S_OFFER:        w_next = (abort_in || w_expire) ? S_STOP : S_OFFER;
      S_STOP:         w_next = r_aborted ? S_IDLE : S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx       <= '0;
      r_shift     <= '0;
      r_value     <= '0;
      r_valid     <= 1'b0;
      r_start     <= 1'b0;
      r_aborted   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_idx       <= (w_bad || w_good) ? '0 : w_accept ? r_idx + 1'b1 : r_idx;
      r_shift     <= w_accept ? {syn_bit_in, r_shift[N-1:1]} : r_shift;
      r_value     <= r_state == S_PUBLISH ? r_shift : r_value;
      r_valid     <= r_state == S_PUBLISH;
      r_start     <= w_fire;
      r_aborted   <= abort_in && r_state == S_OFFER;
      r_frame_err <= r_frame_err || w_bad;
    end
  end

  assign measurement_value_out = r_value;
  assign measurement_valid_out = r_valid;
  assign start_offer           = r_start;
  assign stop_offer            = r_state == S_STOP;
  assign done                  = r_state == S_DONE;
  assign busy                  = r_state != S_IDLE;
  assign frame_err             = r_frame_err;

`ifdef LOADER_DEFECT_COUNT_EN
  localparam int DC_W = $clog2(N + 1);
  logic [DC_W-1:0] r_defect;
  always_ff @(posedge clk) begin
    if (!reset)                   r_defect <= '0;
    else if (r_state == S_PUBLISH) r_defect <= DC_W'($countones(r_shift));
  end
  assign defect_count = r_defect;
`endif
endmodule

// File: tb/tb_syndrome_loader_ctrl.sv
// tb_syndrome_loader_ctrl: randomized frames; expected pulse events queued by stimulus, popped by a monitor.
module tb_syndrome_loader_ctrl;
  localparam int S = 100;
  localparam int O = 2500;

  logic       clk = 1'b0, reset = 1'b0;
  logic       syn_bit_in = 1'b0, syn_valid_in = 1'b0, syn_last_in = 1'b0, abort_in = 1'b0;
  logic       syn_ready_out, measurement_valid_out, start_offer, stop_offer, busy, done, frame_err;
  logic [5:0] measurement_value_out;
`ifdef LOADER_DEFECT_COUNT_EN
  logic [2:0] defect_count;
`endif

  syndrome_loader_ctrl #(
    .GRID_H(2), .GRID_W(3), .SETTLE_CYCLES(S), .OFFER_CYCLES(O), .CNT_WIDTH(16)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .syn_bit_in            (syn_bit_in),
    .syn_valid_in          (syn_valid_in),
    .syn_last_in           (syn_last_in),
    .syn_ready_out         (syn_ready_out),
    .abort_in              (abort_in),
    .measurement_value_out (measurement_value_out),
    .measurement_valid_out (measurement_valid_out),
    .start_offer           (start_offer),
    .stop_offer            (stop_offer),
    .busy                  (busy),
    .done                  (done),
    .frame_err             (frame_err)
`ifdef LOADER_DEFECT_COUNT_EN
    ,
    .defect_count          (defect_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    int         at;
    logic [5:0] val;
  } ev_t;
  ev_t   q[$];
  int    checks = 0, errors = 0;
  logic [5:0] last_vec = '0;
  logic  exp_err = 1'b0;
  string names[4] = '{"valid", "start_offer", "stop_offer", "done"};

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic see(input int k);
    ev_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected %s: got pulse expected none (cycle %0d)", names[k], cyc);
    end else begin
      e = q.pop_front();
      chk({names[k], " kind"}, k, e.kind);
      chk({names[k], " cycle"}, cyc, e.at);
      chk({names[k], " busy"}, busy, 1);
      chk({names[k], " ready"}, syn_ready_out, 0);
      if (k == 0) begin
        chk("published value", measurement_value_out, e.val);
`ifdef LOADER_DEFECT_COUNT_EN
        chk("defect_count", defect_count, $countones(e.val));
`endif
      end
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] p;
    p = {done, stop_offer, start_offer, measurement_valid_out};
    for (int k = 0; k < 4; k++) if (p[k]) see(k);
  end

  task automatic push(input int k, input int at, input logic [5:0] v);
    ev_t e;
    e.kind = k;
    e.at   = at;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic send_bit(input logic b, input logic l, output int t);
    int n = 0;
    syn_valid_in = 1'b1;
    syn_bit_in   = b;
    syn_last_in  = l;
    while (!syn_ready_out && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) chk("ready timeout", 0, 1);
    t = cyc;
    @(negedge clk);
    syn_valid_in = 1'b0;
    syn_last_in  = 1'b0;
  endtask

  task automatic send_frame(input logic [5:0] v, input int nbits, input int lastpos, input int gap,
                            output int t);
    for (int i = 0; i < nbits; i++) begin
      send_bit(v[i], i == lastpos, t);
      if (i < nbits - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic expect_normal(input logic [5:0] v, input int t);
    push(0, t + 2, v);
    push(1, t + 3 + S, v);
    push(2, t + 4 + S + O, v);
    push(3, t + 5 + S + O, v);
    last_vec = v;
  endtask

  task automatic wait_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("returned to idle", busy, 0);
    @(negedge clk);
  endtask

  task automatic good_frame(input logic [5:0] v, input int gap);
    int t;
    send_frame(v, 6, 5, gap, t);
    expect_normal(v, t);
    wait_idle();
    chk("frame_err after good frame", frame_err, exp_err);
  endtask

  task automatic abort_offer(input int offset);
    int t, a;
    logic [5:0] v;
    v = 6'($urandom);
    send_frame(v, 6, 5, 0, t);
    a = t + 3 + S + offset;
    push(0, t + 2, v);
    push(1, t + 3 + S, v);
    push(2, a + 1, v);
    last_vec = v;
    wait_cycle(a);
    abort_in = 1'b1;
    @(negedge clk);
    abort_in = 1'b0;
    chk("busy during abort stop", busy, 1);
    @(negedge clk);
    chk("busy after offer abort", busy, 0);
    chk("ready after offer abort", syn_ready_out, 1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " valid"}, measurement_valid_out, 0);
    chk({tag, " start"}, start_offer, 0);
    chk({tag, " stop"}, stop_offer, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " frame_err"}, frame_err, 0);
    chk({tag, " value"}, measurement_value_out, 0);
  endtask

  initial begin
    #(80000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, k;
    logic [5:0] v;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b1;
    @(negedge clk);
    good_frame(6'b000011, 0);
    // stalled handshake, then valid held while busy must be ignored
    v = 6'($urandom);
    send_frame(v, 6, 5, 1, t);
    expect_normal(v, t);
    syn_valid_in = 1'b1;
    syn_bit_in   = 1'b1;
    repeat (20) @(negedge clk);
    syn_valid_in = 1'b0;
    wait_idle();
    // early last: framing error, vector retained
    send_frame(6'($urandom), 4, 3, 0, t);
    @(negedge clk);
    exp_err = 1'b1;
    chk("frame_err early last", frame_err, 1);
    chk("busy after framing error", busy, 0);
    chk("value retained after error", measurement_value_out, last_vec);
    good_frame(6'($urandom), 0);
    abort_offer(1000);
    abort_offer(O);
    // abort during settle, including the expiry cycle
    for (int r = 0; r < 2; r++) begin
      k = r == 0 ? int'($urandom_range(0, S - 1)) : S;
      v = 6'($urandom);
      send_frame(v, 6, 5, 0, t);
      push(0, t + 2, v);
      last_vec = v;
      wait_cycle(t + 2 + k);
      abort_in = 1'b1;
      @(negedge clk);
      abort_in = 1'b0;
      chk("busy after settle abort", busy, 0);
      repeat (S + 5) @(negedge clk);
    end
    // reset during settle
    v = 6'($urandom);
    send_frame(v, 6, 5, 0, t);
    push(0, t + 2, v);
    wait_cycle(t + 52);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("mid-settle reset");
    reset = 1'b1;
    last_vec = '0;
    exp_err = 1'b0;
    repeat (S + 5) @(negedge clk);
    chk("no pulse leak after reset", q.size(), 0);
    good_frame(6'b110101, 0);
    // missing last on final bit
    send_frame(6'($urandom), 6, -1, 0, t);
    @(negedge clk);
    exp_err = 1'b1;
    chk("frame_err missing last", frame_err, 1);
    chk("value retained after missing last", measurement_value_out, last_vec);
    for (int r = 0; r < 2; r++) good_frame(6'($urandom), int'($urandom_range(0, 2)));
    repeat (5) @(negedge clk);
    chk("pending expected events", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
